uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//   Frame sequencer for the UART transmitter. Sequences one frame: start bit, DATA_WIDTH data bits, optional parity, stop.
//   It drives the TX output mux select and the serializer enable/load strobes.
//   Sits between the TX request interface and the serializer/parity/mux datapath, one bit per CLK (prescaled tx clock).
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame; sizes bit counter ($clog2(DATA_WIDTH) bits)
// PORTS
//   CLK         in   1  transmit bit clock; all state on posedge
//   RST         in   1  asynchronous, active-low reset
//   data_valid  in   1  frame request; data present on serializer input this cycle
//   par_en      in   1  parity enable; sampled only at frame accept
//   load        out  1  serializer parallel-load strobe (accept pulse)
//   ser_en      out  1  serializer shift enable, high for each data-bit cycle
//   mux_sel     out  2  00 start, 01 stop/idle, 10 serial data, 11 parity
//   busy        out  1  frame in progress
// BEHAVIOUR
//   - Reset (RST low, async): state=IDLE, bit_cnt=0, par_q=0; outputs mux_sel=01, ser_en=0, load=0, busy=0.
//   - State register updates on CLK posedge. mux_sel, ser_en and busy are Moore outputs decoded from the state.
//   - load is Mealy: load = data_valid & (state==IDLE | state==STOP). A cycle where load is high is an "accept".
//   - Downstream mux output is registered, so the line shows each mux_sel value one CLK later. This lag is uniform and needs no compensation.
//   - IDLE: mux_sel=01, busy=0.
//     On accept: par_q<=par_en and go to START.
//   - START: mux_sel=00, busy=1, ser_en=0.
//     Clear bit_cnt and go to DATA after one cycle.
//   - DATA: mux_sel=10, ser_en=1, busy=1. bit_cnt increments each cycle.
//     When bit_cnt==DATA_WIDTH-1: go to PARITY if par_q, else go to STOP.
//     Exactly DATA_WIDTH cycles are spent in DATA.
//   - PARITY: mux_sel=11, busy=1, ser_en=0. Lasts one cycle, then go to STOP (or STOP2, see CONFIGURATION).
//   - STOP: mux_sel=01, busy=1.
//     On accept: go straight to START (back-to-back frame, no idle gap) with par_q<=par_en.
//     Otherwise go to IDLE.
//   - data_valid is ignored in START, DATA and PARITY (and STOP2). Requesters must hold or retry until load is seen.
//   - par_en changes mid-frame have no effect; parity presence is fixed by par_q at accept.
//   - Frame length in cycles: 1 + DATA_WIDTH + par_q + 1 (+1 with STOP2).
//   - Mid-frame reset aborts immediately: mux_sel=01, so the line returns to idle-high after the mux register stage.
//   - Illegal or unreached state encodings go to IDLE (default branch).
// CONFIGURATION
//   UART_TX_STOP2_EN defined: after the first stop bit, an extra STOP2 state (mux_sel=01, busy=1) precedes IDLE/accept.
//     Accept is then evaluated in STOP2, not STOP.
//   Undefined: single stop bit; STOP2 is not compiled and its encoding does not exist.
// STRUCTURE
//   - Package uart_tx_pkg holds:
//     - state enum: IDLE, START, DATA, PARITY, STOP, STOP2.
//     - mux select constants: SEL_START=2'b00, SEL_STOP=2'b01, SEL_DATA=2'b10, SEL_PAR=2'b11. These must match the TX mux encoding.
//   - No sub-module. The bit counter is an inline register; its width comes from $clog2(DATA_WIDTH), minimum 1.
// TESTING
//   1. Reset: hold RST=0, toggle CLK -> mux_sel=01, busy=0, ser_en=0, load=0.
//      Release RST -> outputs stay the same with data_valid=0.
//   2. Single frame, par_en=0, DATA_WIDTH=8: pulse data_valid for one cycle in IDLE.
//      -> load=1 in that cycle; mux_sel sequence 00, 10x8, 01 then 01 idle.
//      -> ser_en high for exactly 8 cycles; busy high for 10 cycles.
//   3. Parity frame, par_en=1 at accept, then par_en=0 during DATA.
//      -> sequence 00, 10x8, 11, 01; busy high for 11 cycles.
//   4. Back-to-back: hold data_valid=1 continuously.
//      -> load pulses every 10 cycles, once in IDLE and then in each STOP cycle; the sequence goes STOP -> START with no IDLE cycle.
//      -> no load occurs during START, DATA or PARITY.
//   5. Mid-frame reset: assert RST at DATA bit_cnt=4.
//      -> mux_sel=01, busy=0, ser_en=0 immediately (async).
//      -> the next accept after release restarts at START with bit_cnt=0.
//   6. With UART_TX_STOP2_EN, par_en=0: sequence 00, 10x8, 01, 01.
//      -> load is accepted only in STOP2; busy high for 11 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
// Optional feature macro: UART_TX_STOP2_EN (adds a second stop-bit state).
package uart_tx_pkg;

    // Frame sequencer states; STOP2 exists only when two stop bits are built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_STOP2_EN
        ,
        STOP2  = 3'd5
`endif
    } state_t;

    // TX output mux select encoding; must match the mux datapath
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    // Bit counter width for a given data width, never below one bit
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data bits, optional parity, stop.
// Drives the TX mux select and the serializer load/shift strobes.
// Optional feature macro: UART_TX_STOP2_EN (second stop bit; accept moves to STOP2).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       data_valid,
    input  logic       par_en,
    output logic       load,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       busy
);

    localparam int unsigned    CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_q;
    logic             accept_win;

    // Accept window: idle, or the final stop cycle for back-to-back frames
`ifdef UART_TX_STOP2_EN
    assign accept_win = (state == IDLE) || (state == STOP2);
`else
    assign accept_win = (state == IDLE) || (state == STOP);
`endif

    // Load strobe is combinational so the serializer captures data in the accept cycle
    assign load = data_valid & accept_win;

    // State, bit counter, parity latch and registered Moore outputs of the next state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            mux_sel <= SEL_STOP;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ser_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= START;
                        par_q   <= par_en;
                        mux_sel <= SEL_START;
                        busy    <= 1'b1;
                    end else begin
                        mux_sel <= SEL_STOP;
                        busy    <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    mux_sel <= SEL_DATA;
                    ser_en  <= 1'b1;
                    busy    <= 1'b1;
                end
                DATA: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    busy    <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_q) begin
                            state   <= PARITY;
                            mux_sel <= SEL_PAR;
                        end else begin
                            state   <= STOP;
                            mux_sel <= SEL_STOP;
                        end
                    end else begin
                        mux_sel <= SEL_DATA;
                        ser_en  <= 1'b1;
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    mux_sel <= SEL_STOP;
                    busy    <= 1'b1;
                end
`ifdef UART_TX_STOP2_EN
                STOP: begin
                    state   <= STOP2;
                    mux_sel <= SEL_STOP;
                    busy    <= 1'b1;
                end
                STOP2: begin
`else
                STOP: begin
`endif
                    if (load) begin
                        state   <= START;
                        par_q   <= par_en;
                        mux_sel <= SEL_START;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        mux_sel <= SEL_STOP;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mux_sel <= SEL_STOP;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: random requests against a frame-level
// reference model; expectations are queued per cycle and checked by a monitor.
module tb_uart_tx_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic       load;
        logic [1:0] mux;
        logic       ser;
        logic       busy;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       data_valid;
    logic       par_en;
    logic       load;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       busy;

    exp_t exp_q[$];
    exp_t frame_q[$];
    int   errors   = 0;
    int   checks   = 0;
    bit   done     = 1'b0;
    bit   mon_done = 1'b0;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .data_valid (data_valid),
        .par_en     (par_en),
        .load       (load),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic [1:0] m, input logic s, input logic b);
        exp_t e;
        e.load = 1'b0;
        e.mux  = m;
        e.ser  = s;
        e.busy = b;
        return e;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {load,mux,ser,busy}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: one entry per line cycle, built from the frame rules
    task automatic push_frame(input logic pe);
        frame_q.push_back(mk(2'b00, 1'b0, 1'b1));
        for (int i = 0; i < int'(W); i++) frame_q.push_back(mk(2'b10, 1'b1, 1'b1));
        if (pe) frame_q.push_back(mk(2'b11, 1'b0, 1'b1));
        frame_q.push_back(mk(2'b01, 1'b0, 1'b1));
`ifdef UART_TX_STOP2_EN
        frame_q.push_back(mk(2'b01, 1'b0, 1'b1));
`endif
    endtask

    // One cycle of stimulus plus the model's prediction for that cycle
    task automatic drive_cycle(input logic dv, input logic pe);
        exp_t e;
        logic acc;
        @(negedge CLK);
        data_valid = dv;
        par_en     = pe;
        e   = (frame_q.size() > 0) ? frame_q[0] : mk(2'b01, 1'b0, 1'b0);
        acc = dv && (frame_q.size() <= 1);
        e.load = acc;
        exp_q.push_back(e);
        if (frame_q.size() > 0) void'(frame_q.pop_front());
        if (acc && RST) push_frame(pe);
    endtask

    // Monitor: compare DUT outputs each cycle against the queued expectation
    initial begin
        exp_t e;
        int   cyc = 0;
        while (!(done && exp_q.size() == 0)) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle%0d", cyc), {load, mux_sel, ser_en, busy}, e);
            end
            cyc++;
            if (cyc > 3000) begin
                errors++;
                $display("FAIL monitor_timeout: got %0d cycles expected completion", cyc);
                break;
            end
        end
        mon_done = 1'b1;
    end

    // Stimulus
    initial begin
        RST        = 1'b0;
        data_valid = 1'b0;
        par_en     = 1'b0;

        // Reset holds idle outputs while the clock runs
        repeat (3) begin
            @(negedge CLK);
            #1;
            check("reset", {load, mux_sel, ser_en, busy}, 5'b0_01_0_0);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0);

        // Single frame without parity
        drive_cycle(1'b1, 1'b0);
        repeat (13) drive_cycle(1'b0, 1'b0);

        // Parity frame; par_en dropped during data must not matter
        drive_cycle(1'b1, 1'b1);
        repeat (13) drive_cycle(1'b0, 1'b0);

        // Back-to-back with data_valid held high
        repeat (40) drive_cycle(1'b1, 1'($urandom_range(0, 1)));
        repeat (14) drive_cycle(1'b0, 1'b0);

        // Random requests with random parity
        repeat (400) drive_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        repeat (14) drive_cycle(1'b0, 1'b0);

        // Mid-frame reset at data bit 4, then a fresh frame
        drive_cycle(1'b1, 1'b0);
        repeat (6) drive_cycle(1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        check("async_reset", {load, mux_sel, ser_en, busy}, 5'b0_01_0_0);
        frame_q.delete();
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0);
        RST = 1'b1;
        drive_cycle(1'b1, 1'b1);
        repeat (14) drive_cycle(1'b0, 1'b0);

        done = 1'b1;
        repeat (3) @(negedge CLK);
        check("monitor_done", {4'b0, mon_done}, 5'b00001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
